// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core_ctrl layer sequencer.
// Optional ACC phase is enabled by defining CORE_CTRL_ACC_EN.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W2L0,
    S_KLOAD,
    S_GAP,
    S_A2L0,
    S_EXEC,
    S_DRAIN,
    S_ACC,
    S_FIN
  } state_t;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_A_P_LO   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_A_X_LO   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Memory enables are active-low, so idle holds CEN/WEN high and all else low.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1800C0000;

  localparam logic [ADDR_W-1:0] XMEM_W_BASE = 11'd1024;

  // Geometry of the 6x6 input, 4x4 output and 3x3 kernel.
  localparam int IN_W  = 6;
  localparam int OUT_W = 4;
  localparam int K_W   = 3;

endpackage

// File: rtl/core_ctrl_agen.sv
// Combinational address generator: maps (phase, kij, t, o) to xmem/pmem addresses.
// The ACC-phase mapping is only selected when CORE_CTRL_ACC_EN builds the ACC state.
module core_ctrl_agen
  import core_ctrl_pkg::*;
#(
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int col     = 8
) (
  input  state_t            phase,
  input  logic [3:0]        kij,
  input  logic [ADDR_W-1:0] t,
  input  logic [3:0]        o,
  output logic [ADDR_W-1:0] a_xmem,
  output logic [ADDR_W-1:0] a_pmem
);

  logic [ADDR_W-1:0] kij_s;
  logic [ADDR_W-1:0] k_s;
  logic [ADDR_W-1:0] o_s;
  logic [ADDR_W-1:0] acc_s;

  assign kij_s = {7'd0, kij};
  assign k_s   = {7'd0, t[3:0]};
  assign o_s   = {7'd0, o};

  // Psum of output o under kernel k sits at the shifted input pixel of that kij.
  assign acc_s = k_s * 11'(len_nij)
               + (o_s / 11'(OUT_W) + k_s / 11'(K_W)) * 11'(IN_W)
               + (o_s % 11'(OUT_W)) + (k_s % 11'(K_W));

  always_comb begin
    a_xmem = '0;
    a_pmem = '0;
    case (phase)
      S_W2L0:  a_xmem = XMEM_W_BASE + kij_s * 11'(col) + t;
      S_A2L0:  a_xmem = t;
      S_DRAIN: a_pmem = kij_s * 11'(len_nij) + t;
      S_ACC:   a_pmem = acc_s;
      default: begin
        a_xmem = '0;
        a_pmem = '0;
      end
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Layer sequencer: walks every kernel position through weight load, activation
// load, execute and drain, emitting a registered 34-bit core instruction.
// Define CORE_CTRL_ACC_EN to append the psum accumulation (ACC) phase.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int col      = 8,
  parameter int gap      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij
);

  localparam int OW = $clog2(len_onij);

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] t_r, t_n;
  logic [ADDR_W-1:0] wr_r, wr_n;
  logic [3:0]        kij_r, kij_n;
  logic [OW-1:0]     o_r, o_n;
  logic [INST_W-1:0] inst_n;
  logic [ADDR_W-1:0] a_xmem_s, a_pmem_s;
  logic [ADDR_W-1:0] agen_t_s;
  logic              xrd_prev_s;

  assign kij        = kij_r;
  assign agen_t_s   = (state_r == S_DRAIN) ? wr_r : t_r;
  // The instruction on the bus last cycle tells us which reads are now landing.
  assign xrd_prev_s = !inst[B_CEN_X] && inst[B_WEN_X];

  core_ctrl_agen #(
    .len_kij (len_kij),
    .len_nij (len_nij),
    .col     (col)
  ) u_agen (
    .phase  (state_r),
    .kij    (kij_r),
    .t      (agen_t_s),
    .o      (4'(o_r)),
    .a_xmem (a_xmem_s),
    .a_pmem (a_pmem_s)
  );

  always_comb begin
    state_n = state_r;
    t_n     = t_r;
    wr_n    = wr_r;
    kij_n   = kij_r;
    o_n     = o_r;
    inst_n  = INST_IDLE;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_n = S_W2L0;
          t_n     = '0;
          wr_n    = '0;
          kij_n   = '0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_W2L0, S_A2L0: begin
        if (t_r < 11'((state_r == S_W2L0) ? col : len_nij)) begin
          inst_n[B_CEN_X]               = 1'b0;
          inst_n[B_A_X_LO +: ADDR_W]    = a_xmem_s;
        end else begin
          inst_n[B_CEN_X]               = 1'b1;
        end
        inst_n[B_L0_WR] = xrd_prev_s;
        if (t_r == 11'((state_r == S_W2L0) ? col : len_nij)) begin
          state_n = (state_r == S_W2L0) ? S_KLOAD : S_EXEC;
          t_n     = '0;
        end else begin
          t_n     = t_r + 11'd1;
        end
      end
      S_KLOAD: begin
        inst_n[B_LOAD]  = 1'b1;
        inst_n[B_L0_RD] = 1'b1;
        if (t_r == 11'(col - 1)) begin
          state_n = S_GAP;
          t_n     = '0;
        end else begin
          t_n     = t_r + 11'd1;
        end
      end
      S_GAP: begin
        if (t_r == 11'(gap - 1)) begin
          state_n = S_A2L0;
          t_n     = '0;
        end else begin
          t_n     = t_r + 11'd1;
        end
      end
      S_EXEC: begin
        inst_n[B_EXEC]  = 1'b1;
        inst_n[B_L0_RD] = 1'b1;
        if (t_r == 11'(len_nij - 1)) begin
          state_n = S_DRAIN;
          t_n     = '0;
          wr_n    = '0;
        end else begin
          t_n     = t_r + 11'd1;
        end
      end
      S_DRAIN: begin
        // t_r counts FIFO reads, wr_r counts the pmem writes trailing them.
        if (ofifo_valid && (t_r < 11'(len_nij))) begin
          inst_n[B_OFIFO_RD] = 1'b1;
          t_n                = t_r + 11'd1;
        end else begin
          inst_n[B_OFIFO_RD] = 1'b0;
        end
        if (inst[B_OFIFO_RD]) begin
          inst_n[B_CEN_P]            = 1'b0;
          inst_n[B_WEN_P]            = 1'b0;
          inst_n[B_A_P_LO +: ADDR_W] = a_pmem_s;
          wr_n                       = wr_r + 11'd1;
          if (wr_r == 11'(len_nij - 1)) begin
            t_n  = '0;
            wr_n = '0;
            if (kij_r == 4'(len_kij - 1)) begin
`ifdef CORE_CTRL_ACC_EN
              state_n = S_ACC;
              o_n     = '0;
`else
              state_n = S_FIN;
`endif
            end else begin
              kij_n   = kij_r + 4'd1;
              state_n = S_W2L0;
            end
          end else begin
            state_n = S_DRAIN;
          end
        end else begin
          wr_n = wr_r;
        end
      end
`ifdef CORE_CTRL_ACC_EN
      S_ACC: begin
        // Per output: len_kij reads, one cycle for the last acc, one idle cycle.
        if (t_r < 11'(len_kij)) begin
          inst_n[B_CEN_P]            = 1'b0;
          inst_n[B_A_P_LO +: ADDR_W] = a_pmem_s;
        end else begin
          inst_n[B_CEN_P]            = 1'b1;
        end
        inst_n[B_ACC] = !inst[B_CEN_P] && inst[B_WEN_P];
        if (t_r == 11'(len_kij + 1)) begin
          t_n = '0;
          if (o_r == OW'(len_onij - 1)) begin
            state_n = S_FIN;
          end else begin
            o_n = o_r + OW'(1);
          end
        end else begin
          t_n = t_r + 11'd1;
        end
      end
`endif
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      t_r     <= '0;
      wr_r    <= '0;
      kij_r   <= '0;
      o_r     <= '0;
      inst    <= INST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_n;
      t_r     <= t_n;
      wr_r    <= wr_n;
      kij_r   <= kij_n;
      o_r     <= o_n;
      inst    <= inst_n;
      busy    <= (state_n != S_IDLE) && (state_n != S_FIN);
      done    <= (state_n == S_FIN);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl; builds the ACC checks when CORE_CTRL_ACC_EN is defined.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam int NK = 9;
  localparam int NN = 36;
  localparam int NO = 16;
  localparam int NC = 8;
  localparam int PHASE_CYC = NK * (2 * NC + 10 + 2 * NN + NN);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard state
  logic [10:0] xq[$];
  logic [10:0] wq[$];
  logic [10:0] aq[$];
  logic        mon_en = 1'b0;
  logic        tog = 1'b0;
  logic        v_prev = 1'b1;
  logic        prev_rd = 1'b0;
  logic        prev_xrd = 1'b0;
  logic        prev_prd = 1'b0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [10:0] last_wr = '0;

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij         (kij)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on every memory access, drives ofifo_valid.
  initial forever begin
    logic [10:0] e;
    logic xrd, prd, pwr;
    @(negedge clk);
    xrd = !inst[19] && inst[18];
    prd = !inst[32] && inst[31];
    pwr = !inst[32] && !inst[31];
    if (mon_en) begin
      if (done) done_cnt++;
      if (inst[6]) begin
        rd_cnt++;
        n_vec++;
        if (v_prev !== 1'b1) begin
          n_err++;
          $display("FAIL ofifo_rd_vs_valid: ofifo_rd=1 with prior valid=%b, required 1", v_prev);
        end
      end
      if (prev_rd) begin
        n_vec++;
        if (pwr !== 1'b1) begin
          n_err++;
          $display("FAIL pmem_wr_after_rd: write strobe=%b, required 1", pwr);
        end
      end
      if (prev_xrd) begin
        n_vec++;
        if (inst[2] !== 1'b1) begin
          n_err++;
          $display("FAIL l0_wr_after_xrd: l0_wr=%b, required 1", inst[2]);
        end
      end
      if (xrd) begin
        n_vec++;
        if (xq.size() == 0) begin
          n_err++;
          $display("FAIL xmem_unexpected: A_xmem=%0d, required no read", inst[17:7]);
        end else begin
          e = xq.pop_front();
          if (inst[17:7] !== e) begin
            n_err++;
            $display("FAIL xmem_addr: A_xmem=%0d, required %0d", inst[17:7], e);
          end
          if (e >= 11'd1024 && kij !== 4'((int'(e) - 1024) / NC)) begin
            n_err++;
            $display("FAIL kij_in_w2l0: kij=%0d, required %0d", kij, (int'(e) - 1024) / NC);
          end
        end
      end
      if (pwr) begin
        wr_cnt++;
        n_vec++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL pmem_wr_unexpected: A_pmem=%0d, required no write", inst[30:20]);
        end else begin
          e = wq.pop_front();
          last_wr = inst[30:20];
          if (inst[30:20] !== e) begin
            n_err++;
            $display("FAIL pmem_wr_addr: A_pmem=%0d, required %0d", inst[30:20], e);
          end
        end
      end
`ifdef CORE_CTRL_ACC_EN
      if (prev_prd) begin
        n_vec++;
        if (inst[33] !== 1'b1) begin
          n_err++;
          $display("FAIL acc_after_read: acc=%b, required 1", inst[33]);
        end
      end
      if (prd) begin
        n_vec++;
        if (aq.size() == 0) begin
          n_err++;
          $display("FAIL pmem_rd_unexpected: A_pmem=%0d, required no read", inst[30:20]);
        end else begin
          e = aq.pop_front();
          if (inst[30:20] !== e) begin
            n_err++;
            $display("FAIL acc_addr: A_pmem=%0d, required %0d", inst[30:20], e);
          end
        end
      end
`endif
      prev_rd  = inst[6];
      prev_xrd = xrd;
      prev_prd = prd;
    end
    ofifo_valid = (mon_en && tog) ? ~ofifo_valid : 1'b1;
    v_prev = ofifo_valid;
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    start = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_vec += 4;
    if (inst !== INST_IDLE) begin n_err++; $display("FAIL reset_inst: inst=%h, required %h", inst, INST_IDLE); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: done=%b, required 0", done); end
    if (kij !== 4'd0) begin n_err++; $display("FAIL reset_kij: kij=%0d, required 0", kij); end
  endtask

  task automatic test_first_read();
    pulse_start();
    n_vec += 2;
    if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: busy=%b, required 1", busy); end
    if (inst !== INST_IDLE) begin n_err++; $display("FAIL start_inst: inst=%h, required %h", inst, INST_IDLE); end
    @(negedge clk);
    n_vec += 3;
    if (inst[19] !== 1'b0 || inst[18] !== 1'b1) begin n_err++; $display("FAIL first_xrd: CEN/WEN=%b%b, required 01", inst[19], inst[18]); end
    if (inst[17:7] !== 11'd1024) begin n_err++; $display("FAIL first_addr: A_xmem=%0d, required 1024", inst[17:7]); end
    if (inst[2] !== 1'b0) begin n_err++; $display("FAIL first_l0_wr: l0_wr=%b, required 0", inst[2]); end
    @(negedge clk);
    n_vec += 2;
    if (inst[2] !== 1'b1) begin n_err++; $display("FAIL second_l0_wr: l0_wr=%b, required 1", inst[2]); end
    if (inst[17:7] !== 11'd1025) begin n_err++; $display("FAIL second_addr: A_xmem=%0d, required 1025", inst[17:7]); end
    do_reset(2);
  endtask

  // Full layer with scoreboard; tg toggles ofifo_valid, pokes pulses start while busy and at FIN.
  task automatic run_layer(input logic tg, input logic pokes);
    int cyc;
    int upper;
    xq.delete(); wq.delete(); aq.delete();
    for (int k = 0; k < NK; k++) begin
      for (int t = 0; t < NC; t++) xq.push_back(11'(1024 + k * NC + t));
      for (int t = 0; t < NN; t++) xq.push_back(11'(t));
      for (int n = 0; n < NN; n++) wq.push_back(11'(k * NN + n));
    end
    upper = PHASE_CYC + 100 + (tg ? NK * 40 : 0);
`ifdef CORE_CTRL_ACC_EN
    for (int o = 0; o < NO; o++)
      for (int k = 0; k < NK; k++)
        aq.push_back(11'(k * NN + (o / 4 + k / 3) * 6 + (o % 4) + (k % 3)));
    upper += NO * (NK + 2);
`endif
    done_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    prev_rd = 1'b0; prev_xrd = 1'b0; prev_prd = 1'b0;
    tog = tg;
    mon_en = 1'b1;
    pulse_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < upper + 50) begin
      @(negedge clk);
      cyc++;
      start = (pokes && (cyc % 257 == 0)) ? 1'b1 : 1'b0;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: no done after %0d cycles, required within %0d", cyc, upper);
    end else if (cyc < PHASE_CYC || cyc > upper) begin
      n_err++;
      $display("FAIL layer_length: %0d cycles, required %0d..%0d", cyc, PHASE_CYC, upper);
    end
    start = pokes;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_fin: busy=%b, required 0", busy); end
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    n_vec += 7;
    if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle: busy=%b, required 0", busy); end
    if (done_cnt !== 1) begin n_err++; $display("FAIL done_count: %0d pulses, required 1", done_cnt); end
    if (wr_cnt !== NK * NN) begin n_err++; $display("FAIL pmem_writes: %0d, required %0d", wr_cnt, NK * NN); end
    if (rd_cnt !== NK * NN) begin n_err++; $display("FAIL ofifo_reads: %0d, required %0d", rd_cnt, NK * NN); end
    if (last_wr !== 11'd323) begin n_err++; $display("FAIL last_pmem_addr: %0d, required 323", last_wr); end
    if (xq.size() != 0 || wq.size() != 0) begin n_err++; $display("FAIL scoreboard_left: xq=%0d wq=%0d, required 0", xq.size(), wq.size()); end
    if (aq.size() != 0) begin n_err++; $display("FAIL acc_left: aq=%0d, required 0", aq.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_start();
    cyc = 0;
    while (!(kij == 4'd4 && inst[1] === 1'b1) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (!(kij == 4'd4 && inst[1] === 1'b1)) begin
      n_err++;
      $display("FAIL exec_kij4_timeout: kij=%0d execute=%b, required 4/1", kij, inst[1]);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec += 4;
    if (inst !== INST_IDLE) begin n_err++; $display("FAIL midrst_inst: inst=%h, required %h", inst, INST_IDLE); end
    if (kij !== 4'd0) begin n_err++; $display("FAIL midrst_kij: kij=%0d, required 0", kij); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: busy=%b, required 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: done=%b, required 0", done); end
    reset = 1'b0;
    pulse_start();
    @(negedge clk);
    n_vec += 2;
    if (inst[19] !== 1'b0 || inst[17:7] !== 11'd1024) begin
      n_err++;
      $display("FAIL restart_addr: CEN_xmem=%b A_xmem=%0d, required 0/1024", inst[19], inst[17:7]);
    end
    if (kij !== 4'd0) begin n_err++; $display("FAIL restart_kij: kij=%0d, required 0", kij); end
    do_reset(2);
  endtask

  initial begin
    test_reset();
    test_first_read();
    run_layer(1'b0, 1'b0);
    run_layer(1'b1, 1'b1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
